// File: rtl/register_table.sv
// Architectural register file of the dual-issue core: 128 x 128-bit, 5 read ports, 2 write ports.
// Reads are combinational (zero latency); writes land at the next rising clk edge.
// No backpressure: every write is accepted, and even-pipe data wins an address collision.
module register_table #(
  parameter int NREGS = 128,
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [0:31]      instr_even,
  input  logic [0:31]      instr_odd,
  input  logic [2:0]       format_even,
  input  logic [2:0]       format_odd,
  output logic [0:WIDTH-1] ra_even,
  output logic [0:WIDTH-1] rb_even,
  output logic [0:WIDTH-1] rc_even,
  output logic [0:WIDTH-1] ra_odd,
  output logic [0:WIDTH-1] rb_odd,
  input  logic [6:0]       rt_addr_even,
  input  logic [6:0]       rt_addr_odd,
  input  logic [0:WIDTH-1] rt_even,
  input  logic [0:WIDTH-1] rt_odd,
  input  logic             reg_write_even,
  input  logic             reg_write_odd
);

  // Instruction formats as decoded upstream; 6 and 7 are reserved and read nothing.
  typedef enum logic [2:0] {
    FMT_RR   = 3'd0,
    FMT_RRR  = 3'd1,
    FMT_RI7  = 3'd2,
    FMT_RI10 = 3'd3,
    FMT_RI16 = 3'd4,
    FMT_RI18 = 3'd5
  } fmt_e;

  // Which operand fields a format actually reads: {use_ra, use_rb, use_rc}.
  // has_rc is 0 for the odd pipe, which has no RC port.
  function automatic logic [2:0] field_use(input logic [2:0] fmt, input logic has_rc);
    logic [2:0] use_bits;
    use_bits = 3'b000;
    case (fmt)
      FMT_RR:   use_bits = 3'b110;
      FMT_RRR:  use_bits = {2'b11, has_rc};
      FMT_RI7:  use_bits = 3'b100;
      FMT_RI10: use_bits = 3'b100;
      default:  use_bits = 3'b000;
    endcase
    return use_bits;
  endfunction

  logic [0:WIDTH-1] regs [NREGS];

  // Source register fields; instruction bit 0 is the MSB.
  logic [6:0] ra_addr_even, rb_addr_even, rc_addr_even;
  logic [6:0] ra_addr_odd, rb_addr_odd;
  logic [2:0] use_even, use_odd;

  assign ra_addr_even = instr_even[18:24];
  assign rb_addr_even = instr_even[11:17];
  assign rc_addr_even = instr_even[25:31];
  assign ra_addr_odd  = instr_odd[18:24];
  assign rb_addr_odd  = instr_odd[11:17];

  assign use_even = field_use(format_even, 1'b1);
  assign use_odd  = field_use(format_odd, 1'b0);

  // Opcode and RT bits are not needed by the read decode.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr_even[0:10], instr_odd[0:10], instr_odd[25:31]};

  // Writeback: odd first, then even, so the even pipe overrides a same-address write.
  // Reset clears the whole array asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (reg_write_odd) begin
        regs[rt_addr_odd] <= rt_odd;
      end
      if (reg_write_even) begin
        regs[rt_addr_even] <= rt_even;
      end
    end
  end

  // Combinational operand reads; unused operands and all ports during reset drive 0.
  // No bypass: a read in the write cycle sees the stored (pre-edge) value.
  always_comb begin
    ra_even = '0;
    rb_even = '0;
    rc_even = '0;
    ra_odd  = '0;
    rb_odd  = '0;
    if (reset) begin
      if (use_even[2]) ra_even = regs[ra_addr_even];
      if (use_even[1]) rb_even = regs[rb_addr_even];
      if (use_even[0]) rc_even = regs[rc_addr_even];
      if (use_odd[2])  ra_odd  = regs[ra_addr_odd];
      if (use_odd[1])  rb_odd  = regs[rb_addr_odd];
    end
  end

endmodule

// File: tb/tb_register_table.sv
// Directed bench for register_table: reset clearing, writes, cross-pipe reads,
// collisions, format masking and asynchronous mid-run reset.
module tb_register_table;

  logic         clk;
  logic         reset;
  logic [0:31]  instr_even, instr_odd;
  logic [2:0]   format_even, format_odd;
  logic [0:127] ra_even, rb_even, rc_even, ra_odd, rb_odd;
  logic [6:0]   rt_addr_even, rt_addr_odd;
  logic [0:127] rt_even, rt_odd;
  logic         reg_write_even, reg_write_odd;

  int vectors;
  int miscompares;

  localparam logic [0:127] VAL_A  = 128'h000A_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [0:127] VAL_C  = 128'h000C_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [0:127] VAL_1  = 128'h1;
  localparam logic [0:127] VAL_2  = 128'h2;
  localparam logic [0:127] VAL_R3 = 128'h3333_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [0:127] VAL_R4 = 128'h4444_ABCD_0000_0000_0000_0000_0000_0004;
  localparam logic [0:127] VAL_R6 = 128'h6666_6666_6666_6666_6666_6666_6666_6666;
  localparam logic [0:127] VAL_R0 = 128'hDEAD_BEEF_0000_0000_0000_0000_CAFE_F00D;
  localparam logic [0:127] VAL_X  = 128'h5555_5555_5555_5555_5555_5555_5555_5555;

  register_table dut (
    .clk            (clk),
    .reset          (reset),
    .instr_even     (instr_even),
    .instr_odd      (instr_odd),
    .format_even    (format_even),
    .format_odd     (format_odd),
    .ra_even        (ra_even),
    .rb_even        (rb_even),
    .rc_even        (rc_even),
    .ra_odd         (ra_odd),
    .rb_odd         (rb_odd),
    .rt_addr_even   (rt_addr_even),
    .rt_addr_odd    (rt_addr_odd),
    .rt_even        (rt_even),
    .rt_odd         (rt_odd),
    .reg_write_even (reg_write_even),
    .reg_write_odd  (reg_write_odd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction word with rt [4:10], rb [11:17], ra [18:24], rc [25:31].
  function automatic logic [0:31] mk(input logic [6:0] rt, input logic [6:0] ra,
                                     input logic [6:0] rb, input logic [6:0] rc);
    logic [0:31] w;
    w = '0;
    w[0:3]   = 4'hB;
    w[4:10]  = rt;
    w[11:17] = rb;
    w[18:24] = ra;
    w[25:31] = rc;
    return w;
  endfunction

  task automatic check(input string tag, input logic [0:127] obs, input logic [0:127] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One write cycle on both pipes; enables drop again 1 time unit after the edge.
  task automatic wr(input logic we_e, input logic [6:0] a_e, input logic [0:127] d_e,
                    input logic we_o, input logic [6:0] a_o, input logic [0:127] d_o);
    reg_write_even = we_e;
    rt_addr_even   = a_e;
    rt_even        = d_e;
    reg_write_odd  = we_o;
    rt_addr_odd    = a_o;
    rt_even        = d_e;
    rt_odd         = d_o;
    @(posedge clk);
    #1;
    reg_write_even = 1'b0;
    reg_write_odd  = 1'b0;
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    reset          = 1'b0;
    instr_even     = mk(7'd1, 7'd5, 7'd9, 7'd5);
    instr_odd      = mk(7'd1, 7'd9, 7'd5, 7'd0);
    format_even    = 3'd1;
    format_odd     = 3'd0;
    rt_addr_even   = 7'd5;
    rt_addr_odd    = 7'd9;
    rt_even        = VAL_X;
    rt_odd         = VAL_X;
    reg_write_even = 1'b1;
    reg_write_odd  = 1'b1;

    // Reset held with writes requested: everything reads 0.
    repeat (2) @(posedge clk);
    #1;
    check("rst_ra_even", ra_even, '0);
    check("rst_rb_even", rb_even, '0);
    check("rst_rc_even", rc_even, '0);
    check("rst_ra_odd",  ra_odd,  '0);
    check("rst_rb_odd",  rb_odd,  '0);
    format_odd = 3'd2;
    #1;
    check("rst_ra_odd_ri7", ra_odd, '0);
    reg_write_even = 1'b0;
    reg_write_odd  = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_drop_r5", ra_even, '0);
    check("rst_drop_r9", rb_even, '0);

    // Even write r5 = A, then read it with an RR instruction.
    wr(1'b1, 7'd5, VAL_A, 1'b0, 7'd0, '0);
    instr_even  = mk(7'd2, 7'd5, 7'd0, 7'd2);
    format_even = 3'd0;
    #1;
    check("rr_ra_r5", ra_even, VAL_A);

    // Odd shlqi (RI7, ra=5, rt=7) while even writes C to r5: no bypass before the edge.
    instr_odd  = mk(7'd7, 7'd5, 7'd9, 7'd0);
    format_odd = 3'd2;
    reg_write_even = 1'b1;
    rt_addr_even   = 7'd5;
    rt_even        = VAL_C;
    #1;
    check("xpipe_pre_edge", ra_odd, VAL_A);
    @(posedge clk);
    #1;
    reg_write_even = 1'b0;
    check("xpipe_post_edge", ra_odd, VAL_C);
    check("xpipe_ri7_rb_masked", rb_odd, '0);

    // Collision on r9: even data 1 beats odd data 2.
    wr(1'b1, 7'd9, VAL_1, 1'b1, 7'd9, VAL_2);
    instr_even  = mk(7'd0, 7'd9, 7'd0, 7'd0);
    format_even = 3'd0;
    instr_odd   = mk(7'd0, 7'd9, 7'd0, 7'd0);
    format_odd  = 3'd3;
    #1;
    check("collide_even", ra_even, VAL_1);
    check("collide_odd",  ra_odd,  VAL_1);

    // Fill r3, r4, r6 and read them through RRR on both pipes.
    wr(1'b1, 7'd3, VAL_R3, 1'b1, 7'd4, VAL_R4);
    wr(1'b1, 7'd6, VAL_R6, 1'b0, 7'd0, '0);
    instr_even  = mk(7'd8, 7'd4, 7'd3, 7'd6);
    format_even = 3'd1;
    instr_odd   = mk(7'd8, 7'd4, 7'd3, 7'd6);
    format_odd  = 3'd1;
    #1;
    check("rrr_ra_even", ra_even, VAL_R4);
    check("rrr_rb_even", rb_even, VAL_R3);
    check("rrr_rc_even", rc_even, VAL_R6);
    check("rrr_ra_odd",  ra_odd,  VAL_R4);
    check("rrr_rb_odd",  rb_odd,  VAL_R3);

    // Format masking on the same field values.
    format_even = 3'd0;
    #1;
    check("rr_rc_masked", rc_even, '0);
    check("rr_rb_even",   rb_even, VAL_R3);
    format_even = 3'd4;
    format_odd  = 3'd4;
    #1;
    check("ri16_ra_even", ra_even, '0);
    check("ri16_rb_even", rb_even, '0);
    check("ri16_rc_even", rc_even, '0);
    check("ri16_ra_odd",  ra_odd,  '0);
    check("ri16_rb_odd",  rb_odd,  '0);
    format_even = 3'd5;
    #1;
    check("ri18_ra_even", ra_even, '0);
    check("ri18_rb_even", rb_even, '0);
    check("ri18_rc_even", rc_even, '0);
    format_even = 3'd2;
    #1;
    check("ri7_ra_even", ra_even, VAL_R4);
    check("ri7_rb_even", rb_even, '0);
    check("ri7_rc_even", rc_even, '0);
    format_even = 3'd7;
    format_odd  = 3'd6;
    #1;
    check("rsvd_ra_even", ra_even, '0);
    check("rsvd_ra_odd",  ra_odd,  '0);

    // Register 0 is ordinary storage.
    wr(1'b0, 7'd0, '0, 1'b1, 7'd0, VAL_R0);
    instr_even  = mk(7'd0, 7'd0, 7'd4, 7'd0);
    format_even = 3'd0;
    #1;
    check("r0_write", ra_even, VAL_R0);
    check("r0_rb_r4", rb_even, VAL_R4);

    // Mid-run reset between edges clears outputs and storage at once.
    #1;
    reset = 1'b0;
    #1;
    check("midrst_ra_even", ra_even, '0);
    check("midrst_rb_even", rb_even, '0);
    reset = 1'b1;
    #1;
    check("midrst_r0_cleared", ra_even, '0);
    check("midrst_r4_cleared", rb_even, '0);
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
